branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch resolution and recovery controller for the 5-stage core. It carries each conditional-branch prediction from ID to EX and compares it with the resolved outcome. It then sequences the response: pipeline flush, PC redirect, and one update strobe to the 2-bit predictor per resolved branch. It sits between the predictor, the hazard unit and the IF-stage PC mux.

## Interface
- PC_W, 32, PC/address width.
- FLUSH_CYC, 2, cycles `flush` is held on a mispredict (legal 1..7).

- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall; freezes all controller state.
- btype_ID  in  1  instruction in ID is a conditional branch.
- pred_ID  in  1  predictor output for that branch (1 = taken).
- pc_ID  in  PC_W  PC of the ID instruction.
- target_ID  in  PC_W  computed branch target of the ID instruction.
- branch_result_EX  in  1  actual outcome of the branch in EX (1 = taken).
- flush  out  1  kill IF/ID contents.
- redirect_valid  out  1  PC mux must load redirect_pc.
- redirect_pc  out  PC_W  corrected fetch address.
- upd_valid  out  1  predictor update strobe (predictor advances only on it).
- upd_taken  out  1  outcome for the update.
- stat_total, stat_miss  out  16 each  statistics counters (see Configuration).

## Operation
- States: IDLE (no branch in EX slot), PEND (captured branch occupies EX slot), FLUSH (mispredict recovery).
- Capture occurs when `btype_ID & ~stall & ~flush`, in IDLE or in a PEND resolution cycle with a correct prediction. It latches the following and then enters/stays in PEND:
  - pred = pred_ID
  - tgt = target_ID
  - fall = pc_ID + 4 (modulo 2^PC_W, carry dropped)
- Resolution happens in every PEND cycle with `~stall`:
  - upd_valid = 1, upd_taken = branch_result_EX, in that cycle only.
  - mispredict = pred ^ branch_result_EX.
- Correct prediction: no flush, no redirect. The next state is PEND if a new branch is captured the same cycle, otherwise IDLE.
- Mispredict:
  - redirect_valid = 1 for this one cycle.
  - redirect_pc = branch_result_EX ? tgt : fall.
  - flush = 1.
  - Any branch in ID this cycle is wrong-path and is not captured.
  - Next state is FLUSH with counter = FLUSH_CYC-1. If FLUSH_CYC == 1, the next state is IDLE.
- FLUSH:
  - flush = 1 and btype_ID is ignored.
  - The counter decrements on each `~stall` cycle.
  - At 0, flush deasserts next cycle and the state returns to IDLE.
- stall high: state, latched fields and counter hold. upd_valid and redirect_valid are forced 0. flush keeps its current value.
- Non-branch instructions never enter the slot; in IDLE all outputs are 0.

## Timing
- Reset (async assert) values: state IDLE, slot cleared, counter 0, all outputs 0, stat counters 0.
- Reset mid-operation discards any pending branch or flush sequence. No update or redirect is emitted.
- Capture latency: a branch captured at edge k resolves in the first non-stalled cycle after k.
- upd_valid, upd_taken, redirect_valid and redirect_pc are combinational from state and branch_result_EX, valid in the resolution cycle (Mealy).
- flush is combinational in the mispredict cycle and comes from state during FLUSH. Total assertion is exactly FLUSH_CYC non-stalled cycles.
- Back-to-back branches with correct predictions resolve one per cycle, with no bubbles.
- Simultaneous mispredict and new ID branch: the mispredict wins and the ID branch is dropped.

## Configuration
- BRANCH_STATS_EN defined:
  - stat_total increments on every upd_valid.
  - stat_miss increments on every mispredict.
  - Both are 16-bit, saturate at 16'hFFFF and clear on reset.
- BRANCH_STATS_EN undefined: the counters are not built, and stat_total and stat_miss are tied to 0.

## Test plan
- Reset during FLUSH (FLUSH_CYC=2, assert reset mid-flush) -> flush falls immediately, state IDLE, no upd_valid, stats 0.
- Branch pc_ID=0x100, target=0x200, pred=1, result=1 -> upd_valid=1, upd_taken=1, no flush or redirect, return to IDLE.
- Same branch, pred=1, result=0 -> redirect_valid=1 and redirect_pc=0x104 in the resolution cycle, flush high for 2 cycles, stat_miss=1.
- pred=0, result=1, with a second branch in ID that same cycle -> redirect_pc=0x200, second branch dropped (no upd_valid for it).
- Three consecutive correctly predicted branches -> three consecutive upd_valid pulses, flush never asserted. Then stall for 3 cycles in PEND -> no pulses and held state, and resolution proceeds after stall drops.
- BRANCH_STATS_EN with 65 540 resolutions -> stat_total saturates at 0xFFFF.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// Bundle between the branch controller and the pipeline: ID/EX branch info in,
// flush/redirect/predictor-update/statistics out.
interface branch_ctrl_if #(
   parameter int PC_W = 32
);
   logic            stall;
   logic            btype_ID;
   logic            pred_ID;
   logic [PC_W-1:0] pc_ID;
   logic [PC_W-1:0] target_ID;
   logic            branch_result_EX;
   logic            flush;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic            upd_valid;
   logic            upd_taken;
   logic [15:0]     stat_total;
   logic [15:0]     stat_miss;

   modport master (
      output stall, btype_ID, pred_ID, pc_ID, target_ID, branch_result_EX,
      input  flush, redirect_valid, redirect_pc, upd_valid, upd_taken,
             stat_total, stat_miss
   );

   modport slave (
      input  stall, btype_ID, pred_ID, pc_ID, target_ID, branch_result_EX,
      output flush, redirect_valid, redirect_pc, upd_valid, upd_taken,
             stat_total, stat_miss
   );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution/recovery controller: carries the ID prediction to EX, emits predictor
// updates, flush and PC redirect. Define BRANCH_STATS_EN to build the statistics counters.
module branch_ctrl #(
   parameter int          PC_W      = 32,
   parameter int unsigned FLUSH_CYC = 2
) (
   input logic          clk,
   input logic          reset,
   branch_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PEND  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [2:0] C_INIT  = 3'(FLUSH_CYC - 1);

   logic [1:0]      r_state;
   logic            r_pred;
   logic [PC_W-1:0] r_tgt;
   logic [PC_W-1:0] r_fall;
   logic [2:0]      r_cnt;

   logic w_resolve;
   logic w_mis;
   logic w_flush;
   logic w_cap;

   assign w_resolve = (r_state == S_PEND) & ~bus.stall;
   assign w_mis     = w_resolve & (r_pred ^ bus.branch_result_EX);
   assign w_flush   = w_mis | (r_state == S_FLUSH);
   // A new branch may enter the slot only when the slot frees without a mispredict.
   assign w_cap     = bus.btype_ID & ~bus.stall & ~w_flush &
                      ((r_state == S_IDLE) | (w_resolve & ~w_mis));

   assign bus.flush          = w_flush;
   assign bus.upd_valid      = w_resolve;
   assign bus.upd_taken      = w_resolve & bus.branch_result_EX;
   assign bus.redirect_valid = w_mis;
   assign bus.redirect_pc    = w_mis ? (bus.branch_result_EX ? r_tgt : r_fall) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pred  <= 1'b0;
         r_tgt   <= '0;
         r_fall  <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_cap) begin
            r_pred <= bus.pred_ID;
            r_tgt  <= bus.target_ID;
            r_fall <= bus.pc_ID + PC_W'(4);
         end
         case (r_state)
            S_IDLE: begin
               if (w_cap) r_state <= S_PEND;
            end
            S_PEND: begin
               if (!bus.stall) begin
                  if (w_mis) begin
                     if (FLUSH_CYC == 1) begin
                        r_state <= S_IDLE;
                     end else begin
                        r_state <= S_FLUSH;
                        r_cnt   <= C_INIT;
                     end
                  end else if (w_cap) begin
                     r_state <= S_PEND;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_FLUSH: begin
               // The mispredict cycle already counted as one flush cycle.
               if (!bus.stall) begin
                  r_cnt <= r_cnt - 3'd1;
                  if (r_cnt <= 3'd1) r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   logic [15:0] r_total;
   logic [15:0] r_miss;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_total <= '0;
         r_miss  <= '0;
      end else begin
         if (w_resolve && (r_total != 16'hFFFF)) r_total <= r_total + 16'd1;
         if (w_mis && (r_miss != 16'hFFFF))      r_miss  <= r_miss + 16'd1;
      end
   end

   assign bus.stat_total = r_total;
   assign bus.stat_miss  = r_miss;
`else
   assign bus.stat_total = '0;
   assign bus.stat_miss  = '0;
`endif
endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: a slot/flush-budget reference model predicts each
// cycle's outputs; a negedge monitor pops and compares.
module tb_branch_ctrl;
   localparam int PW = 32;
   localparam int FC = 2;

   logic clk = 1'b0;
   logic reset;

   branch_ctrl_if #(.PC_W(PW)) bus ();

   branch_ctrl #(.PC_W(PW), .FLUSH_CYC(FC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          taken;
      bit          redir;
      logic [31:0] pc;
   } upd_t;

   typedef struct {
      bit          flush;
      bit          upd;
      logic [15:0] total;
      logic [15:0] miss;
   } cyc_t;

   upd_t updq[$];
   cyc_t cycq[$];

   int checks = 0;
   int failures = 0;

   // Reference model: one optional in-flight branch plus a budget of remaining flush cycles.
   bit          m_slot_v;
   bit          m_pred;
   logic [31:0] m_tgt;
   logic [31:0] m_fall;
   int          m_flush_left;
   int          m_total;
   int          m_miss;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit st, input bit bt, input bit pr,
                             input logic [31:0] pc, input logic [31:0] tg, input bit res);
      cyc_t c;
      upd_t u;
      bit   resolving, mis, cap, fl;
      if (rst) begin
         m_slot_v = 0; m_flush_left = 0; m_total = 0; m_miss = 0;
         c.flush = 0; c.upd = 0; c.total = 16'd0; c.miss = 16'd0;
         cycq.push_back(c);
         return;
      end
      resolving = m_slot_v && !st;
      mis = resolving && (m_pred != res);
      fl = (m_flush_left > 0) || mis;
      cap = bt && !st && !fl && (!m_slot_v || (resolving && !mis));
`ifdef BRANCH_STATS_EN
      c.total = 16'(m_total);
      c.miss  = 16'(m_miss);
`else
      c.total = 16'd0;
      c.miss  = 16'd0;
`endif
      c.flush = fl;
      c.upd   = resolving;
      cycq.push_back(c);
      if (resolving) begin
         u.taken = res;
         u.redir = mis;
         u.pc    = mis ? (res ? m_tgt : m_fall) : 32'd0;
         updq.push_back(u);
         if (m_total < 65535) m_total++;
         if (mis && m_miss < 65535) m_miss++;
         m_slot_v = 0;
      end
      if (m_flush_left > 0 && !st) m_flush_left--;
      if (mis) m_flush_left = FC - 1;
      if (cap) begin
         m_slot_v = 1;
         m_pred   = pr;
         m_tgt    = tg;
         m_fall   = pc + 32'd4;
      end
   endtask

   task automatic cyc(input bit rst, input bit st, input bit bt, input bit pr,
                      input logic [31:0] pc, input logic [31:0] tg, input bit res);
      @(posedge clk);
      #1;
      reset                = rst;
      bus.stall            = st;
      bus.btype_ID         = bt;
      bus.pred_ID          = pr;
      bus.pc_ID            = pc;
      bus.target_ID        = tg;
      bus.branch_result_EX = res;
      model_step(rst, st, bt, pr, pc, tg, res);
   endtask

   always @(negedge clk) begin
      if (cycq.size() > 0) begin
         cyc_t c;
         c = cycq.pop_front();
         chk("flush", 32'(bus.flush), 32'(c.flush));
         chk("upd_valid", 32'(bus.upd_valid), 32'(c.upd));
         chk("stat_total", 32'(bus.stat_total), 32'(c.total));
         chk("stat_miss", 32'(bus.stat_miss), 32'(c.miss));
         if (!bus.upd_valid) begin
            chk("idle_redirect_valid", 32'(bus.redirect_valid), 32'd0);
            chk("idle_upd_taken", 32'(bus.upd_taken), 32'd0);
         end
      end
      if (bus.upd_valid === 1'b1) begin
         if (updq.size() == 0) begin
            chk("upd_unexpected", 32'd1, 32'd0);
         end else begin
            upd_t u;
            u = updq.pop_front();
            chk("upd_taken", 32'(bus.upd_taken), 32'(u.taken));
            chk("redirect_valid", 32'(bus.redirect_valid), 32'(u.redir));
            chk("redirect_pc", bus.redirect_pc, u.pc);
         end
      end
   end

   initial begin
      reset = 1'b1;
      bus.stall = 0; bus.btype_ID = 0; bus.pred_ID = 0;
      bus.pc_ID = '0; bus.target_ID = '0; bus.branch_result_EX = 0;
      m_slot_v = 0; m_pred = 0; m_tgt = '0; m_fall = '0;
      m_flush_left = 0; m_total = 0; m_miss = 0;

      repeat (3) cyc(1, 0, 0, 0, 32'h0, 32'h0, 0);
      cyc(0, 0, 0, 0, 32'h0, 32'h0, 0);

      // Correct taken prediction.
      cyc(0, 0, 1, 1, 32'h100, 32'h200, 0);
      cyc(0, 0, 0, 0, 32'h0, 32'h0, 1);
      cyc(0, 0, 0, 0, 32'h0, 32'h0, 0);
      // Predicted taken, actually not taken: redirect to fall-through.
      cyc(0, 0, 1, 1, 32'h100, 32'h200, 0);
      cyc(0, 0, 0, 0, 32'h0, 32'h0, 0);
      repeat (3) cyc(0, 0, 0, 0, 32'h0, 32'h0, 0);
      // Predicted not taken, actually taken, with a wrong-path branch in ID.
      cyc(0, 0, 1, 0, 32'h100, 32'h200, 0);
      cyc(0, 0, 1, 1, 32'h300, 32'h400, 1);
      repeat (3) cyc(0, 0, 0, 0, 32'h0, 32'h0, 0);
      // Three back-to-back correct branches, then a stalled PEND.
      cyc(0, 0, 1, 1, 32'h500, 32'h600, 0);
      cyc(0, 0, 1, 0, 32'h504, 32'h700, 1);
      cyc(0, 0, 1, 1, 32'h508, 32'h800, 0);
      cyc(0, 0, 1, 0, 32'h50C, 32'h900, 1);
      repeat (3) cyc(0, 1, 1, 1, 32'h510, 32'hA00, 1);
      cyc(0, 0, 0, 0, 32'h0, 32'h0, 0);
      cyc(0, 0, 0, 0, 32'h0, 32'h0, 0);
      // Fall-through address wraps.
      cyc(0, 0, 1, 1, 32'hFFFF_FFFC, 32'h40, 0);
      cyc(0, 0, 0, 0, 32'h0, 32'h0, 0);
      repeat (2) cyc(0, 0, 0, 0, 32'h0, 32'h0, 0);
      // Reset asserted in the FLUSH state.
      cyc(0, 0, 1, 0, 32'h100, 32'h200, 0);
      cyc(0, 0, 0, 0, 32'h0, 32'h0, 1);
      cyc(1, 0, 0, 0, 32'h0, 32'h0, 0);
      cyc(0, 0, 0, 0, 32'h0, 32'h0, 0);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] pc, tg;
         pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         tg = $urandom & 32'hFFFF_FFFC;
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) == 0),
             1'($urandom), 1'($urandom), pc, tg, 1'($urandom));
      end
      cyc(1, 0, 0, 0, 32'h0, 32'h0, 0);

      // Long run of correct resolutions to saturate the total counter.
      for (int i = 0; i < 65541; i++) begin
         cyc(0, 0, 1, 1, 32'h1000, 32'h2000, 1);
      end
      cyc(0, 0, 0, 0, 32'h0, 32'h0, 0);
      cyc(0, 0, 1, 1, 32'h1000, 32'h2000, 0);
      repeat (4) cyc(0, 0, 0, 0, 32'h0, 32'h0, 0);

      repeat (2) @(negedge clk);
      #1;
      chk("updq_drained", 32'(updq.size()), 32'd0);
      chk("cycq_drained", 32'(cycq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
